param_seq_detector: RTL and testbench

PARAM_SEQ_DETECTOR -- requirements
Module: param_seq_detector

---
 rtl/param_seq_detector.sv | 144 ++++++++++++++
 tb/tb_param_seq_detector.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/param_seq_detector.sv
// param_seq_detector
//   Serial pattern detector with guard-pattern isolation and lockout.
//   The last SEQ_LEN valid bits are held in a shift history (MSB = oldest).
//   A full-window match against PATTERN raises a one-cycle registered pulse.
//   The low four bits of the history are also watched for two guard patterns:
//     ISO_PAT  -> ISOLATED: detection is suspended until clr.
//     LOCK_PAT -> LOCKED:   absorbing state; only reset exits it.
//
// Optional feature:
//   SEQ_DET_MATCH_CNT_EN - when defined, match_count is a saturating count of
//                          out pulses. When undefined, match_count is tied to 0.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   in          serial data bit
//   in_valid    in is sampled only when high
//   clr         leaves ISOLATED and flushes the history (ignored in LOCKED)
//   out         registered one-cycle match pulse
//   isolated    high while in ISOLATED
//   locked      high while in LOCKED
//   match_count saturating match counter (0 when the counter is compiled out)
module param_seq_detector #(
    parameter int                 SEQ_LEN  = 12,
    parameter logic [SEQ_LEN-1:0] PATTERN  = 12'b000010010100,
    parameter logic [3:0]         ISO_PAT  = 4'b0110,
    parameter logic [3:0]         LOCK_PAT = 4'b0111,
    parameter int                 CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             clr,
    output logic             out,
    output logic             isolated,
    output logic             locked,
    output logic [CNT_W-1:0] match_count
);

    localparam int FILL_W = $clog2(SEQ_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN);
    localparam logic [FILL_W-1:0] FILL_GUARD = FILL_W'(4);

    typedef enum logic [1:0] {
        DETECT   = 2'd0,
        ISOLATED = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [SEQ_LEN-1:0] hist, hist_nx, new_hist;
    logic [FILL_W-1:0]  fill, fill_nx, new_fill;
    logic               match_nx;
    logic               guard_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DETECT;
            hist  <= '0;
            fill  <= '0;
            out   <= 1'b0;
        end else begin
            state <= state_nx;
            hist  <= hist_nx;
            fill  <= fill_nx;
            out   <= match_nx;
        end
    end

    // All pattern checks look at the history as it will be after this edge,
    // so a match is reported on the same edge that shifts in its last bit.
    always_comb begin
        new_hist = {hist[SEQ_LEN-2:0], in};
        new_fill = (fill == FILL_FULL) ? fill : fill + 1'b1;
        guard_ok = (new_fill >= FILL_GUARD);

        state_nx = state;
        hist_nx  = hist;
        fill_nx  = fill;
        match_nx = 1'b0;

        case (state)
            DETECT: begin
                // clr flushes the window; the bit sampled with it is dropped.
                if (clr) begin
                    hist_nx = '0;
                    fill_nx = '0;
                end else if (in_valid) begin
                    hist_nx = new_hist;
                    fill_nx = new_fill;
                    // Lockout beats isolation beats a main match on one edge.
                    if (guard_ok && new_hist[3:0] == LOCK_PAT)
                        state_nx = LOCKED;
                    else if (guard_ok && new_hist[3:0] == ISO_PAT)
                        state_nx = ISOLATED;
                    else if (new_fill == FILL_FULL && new_hist == PATTERN)
                        match_nx = 1'b1;
                end
            end
            ISOLATED: begin
                // Keep shifting so a lockout pattern is still caught here.
                if (clr) begin
                    state_nx = DETECT;
                    hist_nx  = '0;
                    fill_nx  = '0;
                end else if (in_valid) begin
                    hist_nx = new_hist;
                    fill_nx = new_fill;
                    if (guard_ok && new_hist[3:0] == LOCK_PAT)
                        state_nx = LOCKED;
                end
            end
            LOCKED: begin
                // Absorbing: history frozen, clr ignored.
            end
            default: begin
                state_nx = DETECT;
                hist_nx  = '0;
                fill_nx  = '0;
            end
        endcase
    end

    assign isolated = (state == ISOLATED);
    assign locked   = (state == LOCKED);

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Counts on the edge that raises out, so it is current while out is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (match_nx && cnt != {CNT_W{1'b1}})
            cnt <= cnt + 1'b1;
    end

    assign match_count = cnt;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_param_seq_detector.sv
module tb_param_seq_detector;

`ifdef SEQ_DET_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       in;
    logic       in_valid;
    logic       clr;
    logic       out, isolated, locked;
    logic [7:0] match_count;
    logic       out4, isolated4, locked4;
    logic [1:0] match_count4;

    param_seq_detector u_dut (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .clr(clr),
        .out(out), .isolated(isolated), .locked(locked),
        .match_count(match_count)
    );

    param_seq_detector #(
        .SEQ_LEN(4), .PATTERN(4'b1010), .CNT_W(2)
    ) u_dut4 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .clr(clr),
        .out(out4), .isolated(isolated4), .locked(locked4),
        .match_count(match_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rs;   // apply reset before this vector
        logic i;
        logic v;
        logic c;
        logic eo;
        logic ei;
        logic el;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;
    int   cnt_exp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rs, input logic i, input logic v, input logic c,
                       input logic eo, input logic ei, input logic el);
        vec_t x;
        x.rs = rs; x.i = i; x.v = v; x.c = c; x.eo = eo; x.ei = ei; x.el = el;
        tbl.push_back(x);
    endtask

    // Push n bits MSB first; out expected only on the last bit when last_out.
    task automatic add_bits(input logic rs, input logic [31:0] bits, input int n,
                            input logic ei, input logic el, input logic last_out);
        for (int k = 0; k < n; k++)
            add(rs && k == 0, bits[n-1-k], 1'b1, 1'b0, last_out && k == n-1, ei, el);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; in = 1'b0; in_valid = 1'b0; clr = 1'b0;
        #1;
        chk("reset_out", {31'd0, out}, 32'd0);
        chk("reset_iso", {31'd0, isolated}, 32'd0);
        chk("reset_lock", {31'd0, locked}, 32'd0);
        chk("reset_cnt", {24'd0, match_count}, 32'd0);
        chk("reset_cnt4", {30'd0, match_count4}, 32'd0);
        cnt_exp = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic step(input logic b, input logic v, input logic c);
        @(negedge clk);
        in = b; in_valid = v; clr = c;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] pat;
    logic [31:0] exp_cnt;
    int          c4;
    logic        e4;

    initial begin
        rst = 1'b0; in = 1'b0; in_valid = 1'b0; clr = 1'b0;
        pat = 32'b000010010100;

        // Basic match, idle edge, isolation, suppressed pattern, clr release, rematch.
        add_bits(1'b1, pat, 12, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        add_bits(1'b0, pat, 12, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add_bits(1'b0, pat, 12, 1'b0, 1'b0, 1'b1);
        // Isolation section again from a clean reset: count must read 1.
        add_bits(1'b1, 32'b0110, 4, 1'b0, 1'b0, 1'b0);
        tbl[tbl.size()-1].ei = 1'b1;
        add_bits(1'b0, pat, 12, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add_bits(1'b0, pat, 12, 1'b0, 1'b0, 1'b1);
        // Lockout: absorbing through pattern, clr and ISO_PAT.
        add_bits(1'b1, 32'b0111, 4, 1'b0, 1'b0, 1'b0);
        tbl[tbl.size()-1].el = 1'b1;
        add_bits(1'b0, pat, 12, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        add_bits(1'b0, 32'b0110, 4, 1'b0, 1'b1, 1'b0);

        do_reset();
        foreach (tbl[n]) begin
            if (tbl[n].rs) do_reset();
            step(tbl[n].i, tbl[n].v, tbl[n].c);
            chk($sformatf("v%0d_out", n), {31'd0, out}, {31'd0, tbl[n].eo});
            chk($sformatf("v%0d_iso", n), {31'd0, isolated}, {31'd0, tbl[n].ei});
            chk($sformatf("v%0d_lock", n), {31'd0, locked}, {31'd0, tbl[n].el});
            if (tbl[n].eo && cnt_exp < 255) cnt_exp++;
            exp_cnt = CNT_EN ? cnt_exp : 0;
            chk($sformatf("v%0d_cnt", n), {24'd0, match_count}, exp_cnt);
        end
        // Reset releases lockout and clears everything.
        do_reset();

        // Gaps of three invalid cycles between bits do not shift history.
        for (int k = 0; k < 12; k++) begin
            step(pat[11-k], 1'b1, 1'b0);
            chk($sformatf("gap_bit%0d", k), {31'd0, out}, {31'd0, (k == 11)});
            for (int g = 0; g < 3; g++) begin
                step(1'b1, 1'b0, 1'b0);
                chk($sformatf("gap_idle%0d_%0d", k, g), {31'd0, out}, 32'd0);
            end
        end
        chk("gap_cnt", {24'd0, match_count}, CNT_EN ? 32'd1 : 32'd0);

        // Reset mid-pattern discards the partial history.
        do_reset();
        for (int k = 0; k < 8; k++) step(pat[11-k], 1'b1, 1'b0);
        do_reset();
        for (int k = 8; k < 12; k++) begin
            step(pat[11-k], 1'b1, 1'b0);
            chk($sformatf("rstmid_tail%0d", k), {31'd0, out}, 32'd0);
        end
        for (int k = 0; k < 12; k++) begin
            step(pat[11-k], 1'b1, 1'b0);
            chk($sformatf("rstmid_full%0d", k), {31'd0, out}, {31'd0, (k == 11)});
        end

        // Short overlapping pattern with a 2-bit saturating counter.
        do_reset();
        c4 = 0;
        for (int k = 0; k < 10; k++) begin
            step((k % 2 == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0);
            e4 = (k >= 3) && (k % 2 == 1);
            if (e4 && c4 < 3) c4++;
            chk($sformatf("ovl_out%0d", k), {31'd0, out4}, {31'd0, e4});
            chk($sformatf("ovl_cnt%0d", k), {30'd0, match_count4}, CNT_EN ? c4 : 0);
        end
        step(1'b0, 1'b0, 1'b0);
        chk("ovl_idle_out", {31'd0, out4}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
